global_b_merger: RTL and testbench
==================================

Name: global_b_merger

Overview:
- B-channel merger between the system AXI B channel and the NrClusters Ara cluster B ports.
- The global load/store stage splits one cluster AW into 1..MaxSubBursts system AW bursts (4 KiB and 256-beat limits). Each system burst returns its own B.
- This block collects all sub-burst Bs for one original store and returns exactly one merged B, broadcast to every cluster.
- Replaces the direct B pass-through so clusters see one B per AW.

Parameters:
- NrClusters, 4, number of Ara cluster B ports (power of two, >=1).
- MaxOutstanding, 4, original write requests tracked concurrently (FIFO depth).
- MaxSubBursts, 16, maximum system bursts per original request.
- IdWidth, 5, AXI ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- split_valid_i  in  1  system AW handshake of one sub-burst (aw_valid && aw_ready).
- split_last_i  in  1  qualifies split_valid_i; final sub-burst of the original request.
- split_id_i  in  IdWidth  AW id of the sub-burst.
- split_ready_o  out  1  tracker can accept a new original request; the issuing stage gates its AW acceptance with this.
- sys_b_valid_i  in  1  system B valid.
- sys_b_ready_o  out  1  system B ready.
- sys_b_resp_i  in  2  system B resp.
- sys_b_id_i  in  IdWidth  system B id.
- cl_b_valid_o  out  NrClusters  per-cluster merged B valid.
- cl_b_ready_i  in  NrClusters  per-cluster B ready.
- cl_b_resp_o  out  2  merged resp, shared by all clusters.
- cl_b_id_o  out  IdWidth  merged id, shared by all clusters.
- overflow_o  out  1  sticky: open request exceeded MaxSubBursts.

Behaviour:
- Reset values: split_ready_o=1, sys_b_ready_o=1, cl_b_valid_o=0, cl_b_resp_o=0, cl_b_id_o=0, overflow_o=0. The tracker FIFO is empty, all counters are 0, and the FSM is in COLLECT.
- Issue side:
  - open_cnt counts split_valid_i pulses.
  - When split_valid_i && split_last_i, push {open_cnt+1, split_id_i} into the tracker FIFO and clear open_cnt in the same cycle.
  - split_ready_o = ~fifo_full.
  - A split_valid_i with split_last_i arriving while the FIFO is full is a protocol violation (assertion).
  - If open_cnt reaches MaxSubBursts with a non-last split, set overflow_o (sticky until reset) and saturate open_cnt.
- FSM COLLECT (sys_b_ready_o=1):
  - Each sys B handshake increments b_cnt and folds the resp into merged_resp.
  - Fold priority: DECERR > SLVERR > OKAY > EXOKAY. merged_resp is EXOKAY only if every B was EXOKAY.
  - merged_resp initialises to EXOKAY at the start of each request.
  - Bs may arrive while the FIFO is empty, i.e. before the last split is issued. They are still counted.
  - Completion condition: FIFO non-empty && b_cnt (including any handshake this cycle) == head.cnt.
  - On completion: pop the FIFO, latch the resp and the head id into output registers, reset b_cnt and merged_resp, go to BCAST.
- FSM BCAST (sys_b_ready_o=0):
  - cl_b_valid_o[i] = ~acked_q[i]. Each cluster handshake sets acked_q[i].
  - When all acked (including this cycle), clear acked_q, drive cl_b_valid_o=0 next cycle, return to COLLECT.
  - Clusters may accept in different cycles.
  - Output latency: merged B is visible on cl_b_* in the cycle after the completing system B handshake.
- Simultaneous events:
  - Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot first; split_ready_o still reflects the registered full).
  - A single-burst request (cnt=1) completes on its first B.
- Widths:
  - open_cnt, b_cnt, cnt fields: $clog2(MaxSubBursts+1).
  - Counters never wrap; they saturate at MaxSubBursts.
- Reset mid-operation: all state discarded. Outstanding system Bs after reset are not this block's concern.

Optional Feature:
- Macro: GLOBAL_B_MERGER_ID_CHECK_EN.
- With the macro defined:
  - In COLLECT, when the FIFO is non-empty, each sys B id is compared to head.id.
  - On mismatch, the merged resp is forced to SLVERR for that request and a sticky id_err_q is set.
  - id_err_q is exposed on an extra output port, id_err_o.
- Without the macro: sys_b_id_i is ignored, cl_b_id_o comes from the stored split_id_i, and id_err_o does not exist.

Decomposition:
- ara_pkg additions:
  - b_track_t struct {cnt, id}.
  - Function axi_resp_merge(a, b) implementing the fold priority.
  - Localparam B_CNT_W.
- Sub-module: fifo_v3 from common_cells for the tracker (DEPTH=MaxOutstanding, dtype=b_track_t). FSM, counters and broadcast logic live in the top module.

Test Plan:
- Single burst: split(last, id=3); sys B OKAY id=3 -> next cycle cl_b_valid_o=4'hF, resp=OKAY, id=3; all ready -> valid drops, back to COLLECT.
- Three sub-bursts: 3 splits (third last); Bs OKAY, SLVERR, OKAY -> exactly one cl B with resp=SLVERR after the third B; no cl B after the first two.
- Early B: split, B OKAY, then split(last), B EXOKAY -> one merged B resp=OKAY, id of the split.
- Staggered broadcast: cl_b_ready_i = 0001, then 0110, then 1000 -> each cluster sees valid until its own accept; sys_b_ready_o=0 for those 3 cycles; then sys_b_ready_o=1.
- FIFO full: 4 single-burst requests issued, no Bs -> split_ready_o=0; one B plus broadcast completes -> split_ready_o=1 the cycle after the pop.
- Overflow and reset: 17 non-last splits -> overflow_o=1; assert rst_ni mid-BCAST -> all outputs at reset values, overflow_o=0.

Source files
------------

// File: rtl/global_b_merger_pkg.sv
// Shared types and helpers for the global B-channel merger.
// Holds the AXI response encoding, the merger FSM states, the tracker
// entry layout and the response fold used when combining sub-burst Bs.
package global_b_merger_pkg;

    // The tracker entry layout is fixed here, so these are also the
    // defaults for the merger's MaxSubBursts and IdWidth parameters.
    localparam int unsigned MAX_SUB_BURSTS = 16;
    localparam int unsigned ID_WIDTH       = 5;
    localparam int unsigned B_CNT_W        = $clog2(MAX_SUB_BURSTS + 1);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_BCAST   = 1'b1
    } merge_state_e;

    // One entry per original store: how many system Bs to expect and
    // which id to answer the clusters with.
    typedef struct packed {
        logic [B_CNT_W-1:0]  cnt;
        logic [ID_WIDTH-1:0] id;
    } b_track_t;

    // Severity order used by the fold: EXOKAY lowest, DECERR highest.
    function automatic logic [1:0] axi_resp_rank(input logic [1:0] resp);
        logic [1:0] rank;
        case (resp)
            RESP_EXOKAY: rank = 2'd0;
            RESP_OKAY:   rank = 2'd1;
            RESP_SLVERR: rank = 2'd2;
            default:     rank = 2'd3;
        endcase
        return rank;
    endfunction

    // Keep whichever response is more severe, so a single EXOKAY only
    // survives when every folded response was EXOKAY.
    function automatic logic [1:0] axi_resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (axi_resp_rank(b) > axi_resp_rank(a)) ? b : a;
    endfunction

endpackage

// File: rtl/global_b_merger_fifo.sv
// Tracker FIFO for the global B merger (common_cells fifo_v3 style).
// A push into a full FIFO is accepted when a pop happens in the same
// cycle, because the pop frees the slot first.
module global_b_merger_fifo #(
    parameter int unsigned Depth = 4,
    parameter type dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned UsageW = $clog2(Depth + 1);

    logic [AddrW-1:0]  wr_ptr_q;
    logic [AddrW-1:0]  rd_ptr_q;
    logic [UsageW-1:0] usage_q;
    dtype              mem_q [Depth];
    logic              do_push;
    logic              do_pop;

    assign empty_o = (usage_q == '0);
    assign full_o  = (usage_q == UsageW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == AddrW'(Depth - 1)) ? '0 : wr_ptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == AddrW'(Depth - 1)) ? '0 : rd_ptr_q + AddrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   usage_q <= usage_q + UsageW'(1);
                2'b01:   usage_q <= usage_q - UsageW'(1);
                default: ;
            endcase
        end
    end

    // Storage array; contents are only meaningful while counted in usage.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/global_b_merger.sv
// Global B-channel merger: collects the system Bs of all sub-bursts of
// one original store and broadcasts a single merged B to every cluster.
// Optional sys B id checking is enabled with GLOBAL_B_MERGER_ID_CHECK_EN.
module global_b_merger
    import global_b_merger_pkg::*;
#(
    parameter int unsigned NrClusters     = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned MaxSubBursts   = MAX_SUB_BURSTS,
    parameter int unsigned IdWidth        = ID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  split_valid_i,
    input  logic                  split_last_i,
    input  logic [IdWidth-1:0]    split_id_i,
    output logic                  split_ready_o,
    input  logic                  sys_b_valid_i,
    output logic                  sys_b_ready_o,
    input  logic [1:0]            sys_b_resp_i,
    input  logic [IdWidth-1:0]    sys_b_id_i,
    output logic [NrClusters-1:0] cl_b_valid_o,
    input  logic [NrClusters-1:0] cl_b_ready_i,
    output logic [1:0]            cl_b_resp_o,
    output logic [IdWidth-1:0]    cl_b_id_o,
`ifdef GLOBAL_B_MERGER_ID_CHECK_EN
    output logic                  id_err_o,
`endif
    output logic                  overflow_o
);

    // Counters stop at MaxSubBursts instead of wrapping.
    function automatic logic [B_CNT_W-1:0] sat_inc(input logic [B_CNT_W-1:0] c);
        return (c >= B_CNT_W'(MaxSubBursts)) ? c : c + B_CNT_W'(1);
    endfunction

    merge_state_e          state_q;
    logic [B_CNT_W-1:0]    open_cnt_q;
    logic [B_CNT_W-1:0]    b_cnt_q;
    logic [B_CNT_W-1:0]    b_cnt_next;
    logic [1:0]            merged_q;
    logic [1:0]            merged_next;
    logic [1:0]            final_resp;
    logic [NrClusters-1:0] acked_q;
    logic [NrClusters-1:0] acked_next;
    logic [NrClusters-1:0] cl_valid_q;
    logic [1:0]            out_resp_q;
    logic [IdWidth-1:0]    out_id_q;
    logic                  overflow_q;
    logic                  all_acked;
    logic                  b_hs;
    logic                  complete;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    b_track_t              push_entry;
    b_track_t              head;

    assign push       = split_valid_i && split_last_i;
    assign push_entry = '{cnt: sat_inc(open_cnt_q), id: split_id_i};

    global_b_merger_fifo #(
        .Depth (MaxOutstanding),
        .dtype (b_track_t)
    ) i_tracker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (complete),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign split_ready_o = ~fifo_full;
    assign sys_b_ready_o = (state_q == ST_COLLECT);
    assign b_hs          = sys_b_valid_i && sys_b_ready_o;
    assign cl_b_valid_o  = cl_valid_q;
    assign cl_b_resp_o   = out_resp_q;
    assign cl_b_id_o     = out_id_q;
    assign overflow_o    = overflow_q;

    // Count and fold this cycle's system B, then see if the head request is done.
    always_comb begin
        b_cnt_next  = b_cnt_q;
        merged_next = merged_q;
        if (b_hs) begin
            b_cnt_next  = sat_inc(b_cnt_q);
            merged_next = axi_resp_merge(merged_q, sys_b_resp_i);
        end
        complete = (state_q == ST_COLLECT) && !fifo_empty && (b_cnt_next == head.cnt);
    end

    // Track which clusters have taken the broadcast, including this cycle.
    always_comb begin
        acked_next = acked_q | (cl_b_ready_i & cl_valid_q);
        all_acked  = &acked_next;
    end

`ifdef GLOBAL_B_MERGER_ID_CHECK_EN
    logic req_err_q;
    logic req_err_next;
    logic id_err_q;
    logic id_mismatch;

    // Flag a B whose id does not belong to the request being collected.
    always_comb begin
        id_mismatch  = b_hs && !fifo_empty && (sys_b_id_i != head.id);
        req_err_next = req_err_q | id_mismatch;
        final_resp   = req_err_next ? RESP_SLVERR : merged_next;
    end

    // Per-request error flag plus the sticky error visible to software.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_err_q <= 1'b0;
            id_err_q  <= 1'b0;
        end else begin
            if (id_mismatch) begin
                id_err_q <= 1'b1;
            end
            if (complete) begin
                req_err_q <= 1'b0;
            end else if (state_q == ST_COLLECT) begin
                req_err_q <= req_err_next;
            end
        end
    end

    assign id_err_o = id_err_q;
`else
    logic unused_sys_b_id;
    assign unused_sys_b_id = ^sys_b_id_i;
    assign final_resp      = merged_next;
`endif

    // Issue side: count sub-bursts of the open request and flag oversize requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (split_valid_i) begin
            if (split_last_i) begin
                open_cnt_q <= '0;
            end else begin
                if (open_cnt_q >= B_CNT_W'(MaxSubBursts - 1)) begin
                    overflow_q <= 1'b1;
                end
                open_cnt_q <= sat_inc(open_cnt_q);
            end
        end
    end

    // Collect system Bs, then hold the merged B until every cluster has taken it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_COLLECT;
            b_cnt_q    <= '0;
            merged_q   <= RESP_EXOKAY;
            acked_q    <= '0;
            cl_valid_q <= '0;
            out_resp_q <= RESP_OKAY;
            out_id_q   <= '0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (complete) begin
                        state_q    <= ST_BCAST;
                        cl_valid_q <= '1;
                        out_resp_q <= final_resp;
                        out_id_q   <= head.id;
                        b_cnt_q    <= '0;
                        merged_q   <= RESP_EXOKAY;
                    end else begin
                        b_cnt_q  <= b_cnt_next;
                        merged_q <= merged_next;
                    end
                end
                ST_BCAST: begin
                    if (all_acked) begin
                        state_q    <= ST_COLLECT;
                        acked_q    <= '0;
                        cl_valid_q <= '0;
                    end else begin
                        acked_q    <= acked_next;
                        cl_valid_q <= ~acked_next;
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    // A final sub-burst must never be issued into a full tracker unless a pop frees a slot.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full && !complete));

endmodule

// File: tb/tb_global_b_merger.sv
// Self-checking bench for global_b_merger: directed vector table,
// hand-written corner sequences and a randomized run against a
// transaction-level model of the merge rules.
module tb_global_b_merger;

    localparam int         ID_W   = 5;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam logic [3:0] ALL    = 4'hF;

    logic            clk_i         = 1'b0;
    logic            rst_ni        = 1'b0;
    logic            split_valid_i = 1'b0;
    logic            split_last_i  = 1'b0;
    logic [ID_W-1:0] split_id_i    = '0;
    logic            split_ready_o;
    logic            sys_b_valid_i = 1'b0;
    logic            sys_b_ready_o;
    logic [1:0]      sys_b_resp_i  = '0;
    logic [ID_W-1:0] sys_b_id_i    = '0;
    logic [3:0]      cl_b_valid_o;
    logic [3:0]      cl_b_ready_i  = '0;
    logic [1:0]      cl_b_resp_o;
    logic [ID_W-1:0] cl_b_id_o;
    logic            overflow_o;
`ifdef GLOBAL_B_MERGER_ID_CHECK_EN
    logic            id_err_o;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [1:0]      n;
        logic [2:0][1:0] resp;
        logic [ID_W-1:0] id;
        logic [1:0]      exp_resp;
    } vec_t;

    vec_t vecs [8];

    always #5 clk_i = ~clk_i;

    global_b_merger dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .split_valid_i (split_valid_i),
        .split_last_i  (split_last_i),
        .split_id_i    (split_id_i),
        .split_ready_o (split_ready_o),
        .sys_b_valid_i (sys_b_valid_i),
        .sys_b_ready_o (sys_b_ready_o),
        .sys_b_resp_i  (sys_b_resp_i),
        .sys_b_id_i    (sys_b_id_i),
        .cl_b_valid_o  (cl_b_valid_o),
        .cl_b_ready_i  (cl_b_ready_i),
        .cl_b_resp_o   (cl_b_resp_o),
        .cl_b_id_o     (cl_b_id_o),
`ifdef GLOBAL_B_MERGER_ID_CHECK_EN
        .id_err_o      (id_err_o),
`endif
        .overflow_o    (overflow_o)
    );

    function automatic int resp_rank(input logic [1:0] r);
        case (r)
            EXOKAY:  return 0;
            OKAY:    return 1;
            SLVERR:  return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] rank_to_resp(input int rank);
        case (rank)
            0:       return EXOKAY;
            1:       return OKAY;
            2:       return SLVERR;
            default: return DECERR;
        endcase
    endfunction

    function automatic vec_t mk(input int n, input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input int id, input logic [1:0] exp_resp);
        vec_t v;
        v.n        = 2'(n);
        v.resp[0]  = r0;
        v.resp[1]  = r1;
        v.resp[2]  = r2;
        v.id       = ID_W'(id);
        v.exp_resp = exp_resp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic issue_split(input logic last, input logic [ID_W-1:0] id);
        split_valid_i = 1'b1;
        split_last_i  = last;
        split_id_i    = id;
        tick();
        split_valid_i = 1'b0;
        split_last_i  = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] resp, input logic [ID_W-1:0] id);
        sys_b_valid_i = 1'b1;
        sys_b_resp_i  = resp;
        sys_b_id_i    = id;
        tick();
        sys_b_valid_i = 1'b0;
    endtask

    task automatic ack_all(input string name);
        cl_b_ready_i = ALL;
        tick();
        cl_b_ready_i = '0;
        checkOutput({name, "_valid_drop"}, cl_b_valid_o, 0);
        checkOutput({name, "_sys_ready_back"}, sys_b_ready_o, 1);
    endtask

    // Complete the single-burst request at the FIFO head and check its id.
    task automatic drain_one(input string name, input logic [ID_W-1:0] exp_id);
        send_b(OKAY, exp_id);
        checkOutput({name, "_valid"}, cl_b_valid_o, ALL);
        checkOutput({name, "_id"}, cl_b_id_o, exp_id);
        ack_all(name);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int n;
        string nm;
        n  = int'(v.n);
        nm = $sformatf("vec%0d", idx);
        for (int j = 0; j < n; j++) begin
            issue_split(j == n - 1, v.id);
        end
        for (int j = 0; j < n; j++) begin
            send_b(v.resp[j], v.id);
            if (j < n - 1) begin
                checkOutput($sformatf("%s_no_early_b%0d", nm, j), cl_b_valid_o, 0);
            end
        end
        checkOutput({nm, "_valid"}, cl_b_valid_o, ALL);
        checkOutput({nm, "_resp"}, cl_b_resp_o, v.exp_resp);
        checkOutput({nm, "_id"}, cl_b_id_o, v.id);
        checkOutput({nm, "_sys_ready_bcast"}, sys_b_ready_o, 0);
        ack_all(nm);
    endtask

    task automatic run_random(input int n_req);
        int              req_cnt [$];
        logic [ID_W-1:0] req_id [$];
        logic [1:0]      b_list [$];
        logic [1:0]      exp_resp [$];
        int              req_k        = 0;
        int              split_in_req = 0;
        int              splits_done  = 0;
        int              b_sent       = 0;
        int              bc_seen      = 0;
        int              cyc          = 0;
        logic [3:0]      prev_valid   = '0;
        bit              b_hs;
        int              idle_valid   = 0;

        for (int k = 0; k < n_req; k++) begin
            int c;
            int worst;
            c     = $urandom_range(1, 4);
            worst = 0;
            req_cnt.push_back(c);
            req_id.push_back(ID_W'($urandom));
            for (int j = 0; j < c; j++) begin
                logic [1:0] r;
                r = 2'($urandom);
                b_list.push_back(r);
                if (resp_rank(r) > worst) worst = resp_rank(r);
            end
            exp_resp.push_back(rank_to_resp(worst));
        end

        while (bc_seen < n_req && cyc < 20000) begin
            split_valid_i = 1'b0;
            split_last_i  = 1'b0;
            if (req_k < n_req && split_ready_o && $urandom_range(0, 2) != 0) begin
                split_valid_i = 1'b1;
                split_id_i    = req_id[req_k];
                split_last_i  = (split_in_req == req_cnt[req_k] - 1);
            end
            sys_b_valid_i = 1'b0;
            if (b_sent < splits_done && $urandom_range(0, 2) != 0) begin
                sys_b_valid_i = 1'b1;
                sys_b_resp_i  = b_list[b_sent];
                sys_b_id_i    = ID_W'($urandom);
            end
            cl_b_ready_i = 4'($urandom);
            b_hs         = sys_b_valid_i && sys_b_ready_o;

            @(negedge clk_i);
            if (cl_b_valid_o != 0 && prev_valid == 0) begin
                checkOutput($sformatf("rnd%0d_valid", bc_seen), cl_b_valid_o, ALL);
                checkOutput($sformatf("rnd%0d_resp", bc_seen), cl_b_resp_o, exp_resp[bc_seen]);
                checkOutput($sformatf("rnd%0d_id", bc_seen), cl_b_id_o, req_id[bc_seen]);
                bc_seen++;
            end
            prev_valid = cl_b_valid_o;

            tick();
            cyc++;
            if (split_valid_i) begin
                splits_done++;
                if (split_last_i) begin
                    req_k++;
                    split_in_req = 0;
                end else begin
                    split_in_req++;
                end
            end
            if (b_hs) b_sent++;
        end

        split_valid_i = 1'b0;
        split_last_i  = 1'b0;
        sys_b_valid_i = 1'b0;
        cl_b_ready_i  = ALL;
        tick();
        cl_b_ready_i  = '0;
        for (int i = 0; i < 8; i++) begin
            if (cl_b_valid_o != 0) idle_valid++;
            tick();
        end
        checkOutput("rnd_broadcast_count", bc_seen, n_req);
        checkOutput("rnd_all_b_sent", b_sent, b_list.size());
        checkOutput("rnd_no_extra_b", idle_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = mk(1, OKAY,   OKAY,   OKAY,   3,  OKAY);
        vecs[1] = mk(1, EXOKAY, OKAY,   OKAY,   10, EXOKAY);
        vecs[2] = mk(3, OKAY,   SLVERR, OKAY,   12, SLVERR);
        vecs[3] = mk(3, EXOKAY, EXOKAY, EXOKAY, 31, EXOKAY);
        vecs[4] = mk(3, EXOKAY, OKAY,   EXOKAY, 0,  OKAY);
        vecs[5] = mk(3, SLVERR, DECERR, OKAY,   17, DECERR);
        vecs[6] = mk(2, DECERR, EXOKAY, OKAY,   8,  DECERR);
        vecs[7] = mk(1, SLVERR, OKAY,   OKAY,   1,  SLVERR);

        // Reset values
        #2;
        checkOutput("rst_split_ready", split_ready_o, 1);
        checkOutput("rst_sys_ready", sys_b_ready_o, 1);
        checkOutput("rst_cl_valid", cl_b_valid_o, 0);
        checkOutput("rst_cl_resp", cl_b_resp_o, 0);
        checkOutput("rst_cl_id", cl_b_id_o, 0);
        checkOutput("rst_overflow", overflow_o, 0);
        #10;
        rst_ni = 1'b1;
        tick();

        // Vector table: single and multi-burst merges
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Early B: one B arrives before the final split is issued
        issue_split(1'b0, 5'd7);
        send_b(OKAY, 5'd7);
        checkOutput("early_no_b", cl_b_valid_o, 0);
        checkOutput("early_sys_ready", sys_b_ready_o, 1);
        issue_split(1'b1, 5'd7);
        send_b(EXOKAY, 5'd7);
        checkOutput("early_valid", cl_b_valid_o, ALL);
        checkOutput("early_resp", cl_b_resp_o, OKAY);
        checkOutput("early_id", cl_b_id_o, 7);
        ack_all("early");

        // Staggered broadcast acceptance
        issue_split(1'b1, 5'd21);
        send_b(SLVERR, 5'd21);
        checkOutput("stag_valid0", cl_b_valid_o, ALL);
        cl_b_ready_i = 4'b0001;
        checkOutput("stag_sys_ready0", sys_b_ready_o, 0);
        tick();
        checkOutput("stag_valid1", cl_b_valid_o, 4'b1110);
        checkOutput("stag_sys_ready1", sys_b_ready_o, 0);
        cl_b_ready_i = 4'b0110;
        tick();
        checkOutput("stag_valid2", cl_b_valid_o, 4'b1000);
        checkOutput("stag_sys_ready2", sys_b_ready_o, 0);
        cl_b_ready_i = 4'b1000;
        tick();
        cl_b_ready_i = '0;
        checkOutput("stag_valid3", cl_b_valid_o, 0);
        checkOutput("stag_sys_ready3", sys_b_ready_o, 1);
        checkOutput("stag_resp", cl_b_resp_o, SLVERR);

        // FIFO full, pop releases it, then push and pop together while full
        for (int i = 1; i <= 4; i++) begin
            issue_split(1'b1, ID_W'(i));
            if (i == 3) checkOutput("full_ready_at3", split_ready_o, 1);
        end
        checkOutput("full_ready_at4", split_ready_o, 0);
        send_b(OKAY, 5'd1);
        checkOutput("full_ready_after_pop", split_ready_o, 1);
        checkOutput("full_pop_id", cl_b_id_o, 1);
        ack_all("full_pop");
        issue_split(1'b1, 5'd9);
        checkOutput("full_again", split_ready_o, 0);
        sys_b_valid_i = 1'b1;
        sys_b_resp_i  = OKAY;
        split_valid_i = 1'b1;
        split_last_i  = 1'b1;
        split_id_i    = 5'd10;
        tick();
        sys_b_valid_i = 1'b0;
        split_valid_i = 1'b0;
        split_last_i  = 1'b0;
        checkOutput("pushpop_ready", split_ready_o, 0);
        checkOutput("pushpop_id", cl_b_id_o, 2);
        ack_all("pushpop");
        drain_one("drain3", 5'd3);
        drain_one("drain4", 5'd4);
        drain_one("drain9", 5'd9);
        drain_one("drain10", 5'd10);
        checkOutput("drained_ready", split_ready_o, 1);

        // Overflow, then reset in the middle of a broadcast
        issue_split(1'b1, 5'd5);
        for (int i = 0; i < 17; i++) begin
            issue_split(1'b0, 5'd6);
            if (i == 13) checkOutput("ovf_not_yet", overflow_o, 0);
        end
        checkOutput("ovf_set", overflow_o, 1);
        send_b(OKAY, 5'd5);
        checkOutput("ovf_bcast_valid", cl_b_valid_o, ALL);
        checkOutput("ovf_bcast_id", cl_b_id_o, 5);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("mid_rst_split_ready", split_ready_o, 1);
        checkOutput("mid_rst_sys_ready", sys_b_ready_o, 1);
        checkOutput("mid_rst_cl_valid", cl_b_valid_o, 0);
        checkOutput("mid_rst_cl_resp", cl_b_resp_o, 0);
        checkOutput("mid_rst_cl_id", cl_b_id_o, 0);
        checkOutput("mid_rst_overflow", overflow_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Randomized traffic against the transaction-level model
        run_random(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
